// File: rtl/chime_pkg.sv
// Shared types and default timing for the doorbell chime controller.
package chime_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DING = 2'd1,
    DONG = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int TONE_LEN_DEF = 8;
  localparam int GAP_LEN_DEF  = 4;
  localparam int CNT_W        = $clog2(256);

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronous button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic r_prev;

  // Previous-sample register; cleared by reset so a held button fires after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= btn;
  end

  assign press = btn & ~r_prev;

endmodule

// File: rtl/chime_controller.sv
// Two-door chime sequencer: front plays ding-dong, back plays dong,
// followed by a silent lockout. Presses during a chime are queued once.
module chime_controller
  import chime_pkg::*;
#(
  parameter int TONE_LEN = TONE_LEN_DEF,
  parameter int GAP_LEN  = GAP_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             front_btn,
  input  logic             back_btn,
  output logic             sel,
  output logic             chime_en,
  output logic             busy,
  output logic [7:0]       ring_count
);

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_f, r_pend_b;
  logic             r_sel, r_chime_en, r_busy;
  logic [7:0]       r_ring;

  logic w_front_press, w_back_press;
  logic w_front_req, w_back_req, w_idle, w_start_f, w_start_b, w_cnt_done;

  btn_edge u_front_edge (.clk(clk), .rst(rst), .btn(front_btn), .press(w_front_press));
  btn_edge u_back_edge  (.clk(clk), .rst(rst), .btn(back_btn),  .press(w_back_press));

  assign w_idle      = (r_state == IDLE);
  assign w_front_req = w_front_press | r_pend_f;
  assign w_back_req  = w_back_press  | r_pend_b;
  // Front always wins an IDLE decision, whether the request is fresh or pending
  assign w_start_f   = w_idle & w_front_req;
  assign w_start_b   = w_idle & ~w_front_req & w_back_req;
  assign w_cnt_done  = (r_cnt == '0);

  // Single-depth pending flags: set by any press not started now, cleared when its chime starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_f <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      r_pend_f <= w_start_f ? 1'b0 : (r_pend_f | w_front_press);
      r_pend_b <= w_start_b ? 1'b0 : (r_pend_b | w_back_press);
    end
  end

  // Chime FSM with phase counter; outputs are registered alongside each state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= 1'b0;
      r_chime_en <= 1'b0;
      r_busy     <= 1'b0;
      r_ring     <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_f) begin
            r_state    <= DING;
            r_cnt      <= TONE_LOAD;
            r_sel      <= 1'b0;
            r_chime_en <= 1'b1;
            r_busy     <= 1'b1;
            r_ring     <= r_ring + 8'd1;
          end else if (w_start_b) begin
            r_state    <= DONG;
            r_cnt      <= TONE_LOAD;
            r_sel      <= 1'b1;
            r_chime_en <= 1'b1;
            r_busy     <= 1'b1;
            r_ring     <= r_ring + 8'd1;
          end
        end
        DING: begin
          if (w_cnt_done) begin
            r_state <= DONG;
            r_cnt   <= TONE_LOAD;
            r_sel   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONG: begin
          if (w_cnt_done) begin
            r_state    <= GAP;
            r_cnt      <= GAP_LOAD;
            r_sel      <= 1'b0;
            r_chime_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (w_cnt_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_sel      <= 1'b0;
          r_chime_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign chime_en   = r_chime_en;
  assign busy       = r_busy;
  assign ring_count = r_ring;

endmodule

// File: tb/tb_chime_controller.sv
// Directed bench for chime_controller with TONE_LEN=8, GAP_LEN=4.
module tb_chime_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       front_btn = 1'b0;
  logic       back_btn = 1'b0;
  logic       sel, chime_en, busy;
  logic [7:0] ring_count;

  int n_vec = 0;
  int n_err = 0;

  chime_controller #(.TONE_LEN(8), .GAP_LEN(4)) dut (
    .clk(clk), .rst(rst), .front_btn(front_btn), .back_btn(back_btn),
    .sel(sel), .chime_en(chime_en), .busy(busy), .ring_count(ring_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; front_btn = 1'b0; back_btn = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; front_btn = 1'b0; back_btn = 1'b0;
    tick; tick;
    n_vec++;
    if ({chime_en, sel, busy, ring_count} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got en/sel/busy/ring=%b%b%b/%0d want 000/0", chime_en, sel, busy, ring_count);
    end
    // button held through reset release counts as a press on the first edge
    front_btn = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    front_btn = 1'b0;
    n_vec++;
    if ({chime_en, sel, busy, ring_count} !== {3'b101, 8'd1}) begin
      n_err++;
      $display("FAIL held_through_reset: got en/sel/busy/ring=%b%b%b/%0d want 101/1", chime_en, sel, busy, ring_count);
    end
  endtask

  task automatic test_front;
    logic [2:0] exp;
    apply_reset;
    front_btn = 1'b1; tick; front_btn = 1'b0;
    for (int i = 0; i < 21; i++) begin
      exp = (i < 8) ? 3'b101 : (i < 16) ? 3'b111 : (i < 20) ? 3'b001 : 3'b000;
      n_vec++;
      if ({chime_en, sel, busy} !== exp) begin
        n_err++;
        $display("FAIL front_seq[%0d]: got en/sel/busy=%b%b%b want %b", i, chime_en, sel, busy, exp);
      end
      tick;
    end
    n_vec++;
    if (ring_count !== 8'd1) begin
      n_err++;
      $display("FAIL front_ring: got %0d want 1", ring_count);
    end
  endtask

  task automatic test_back;
    logic [2:0] exp;
    apply_reset;
    back_btn = 1'b1; tick; back_btn = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp = (i < 8) ? 3'b111 : (i < 12) ? 3'b001 : 3'b000;
      n_vec++;
      if ({chime_en, sel, busy} !== exp) begin
        n_err++;
        $display("FAIL back_seq[%0d]: got en/sel/busy=%b%b%b want %b", i, chime_en, sel, busy, exp);
      end
      tick;
    end
    n_vec++;
    if (ring_count !== 8'd1) begin
      n_err++;
      $display("FAIL back_ring: got %0d want 1", ring_count);
    end
  endtask

  task automatic test_simultaneous;
    logic [2:0] exp;
    apply_reset;
    front_btn = 1'b1; back_btn = 1'b1; tick; front_btn = 1'b0; back_btn = 1'b0;
    // front 20 cycles, one IDLE cycle, back 12 cycles, then idle
    for (int i = 0; i < 35; i++) begin
      exp = (i < 8)  ? 3'b101 : (i < 16) ? 3'b111 : (i < 20) ? 3'b001 :
            (i == 20) ? 3'b000 : (i < 29) ? 3'b111 : (i < 33) ? 3'b001 : 3'b000;
      n_vec++;
      if ({chime_en, sel, busy} !== exp) begin
        n_err++;
        $display("FAIL simul_seq[%0d]: got en/sel/busy=%b%b%b want %b", i, chime_en, sel, busy, exp);
      end
      tick;
    end
    n_vec++;
    if (ring_count !== 8'd2) begin
      n_err++;
      $display("FAIL simul_ring: got %0d want 2", ring_count);
    end
  endtask

  task automatic test_replay;
    logic [2:0] exp;
    apply_reset;
    front_btn = 1'b1; tick; front_btn = 1'b0;
    // three separate presses during the first chime collapse to one replay
    for (int i = 0; i < 52; i++) begin
      exp = (i < 8)  ? 3'b101 : (i < 16) ? 3'b111 : (i < 20) ? 3'b001 :
            (i == 20) ? 3'b000 : (i < 29) ? 3'b101 : (i < 37) ? 3'b111 :
            (i < 41) ? 3'b001 : 3'b000;
      n_vec++;
      if ({chime_en, sel, busy} !== exp) begin
        n_err++;
        $display("FAIL replay_seq[%0d]: got en/sel/busy=%b%b%b want %b", i, chime_en, sel, busy, exp);
      end
      front_btn = (i == 2 || i == 5 || i == 9);
      tick;
    end
    n_vec++;
    if (ring_count !== 8'd2) begin
      n_err++;
      $display("FAIL replay_ring: got %0d want 2", ring_count);
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    front_btn = 1'b1; tick; front_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      front_btn = (i == 3);
      back_btn  = (i == 5);
      tick;
    end
    // now in DONG with both flags pending; assert reset between edges
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({chime_en, sel, busy, ring_count} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got en/sel/busy/ring=%b%b%b/%0d want 000/0", chime_en, sel, busy, ring_count);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      n_vec++;
      if ({chime_en, busy, ring_count} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_no_replay[%0d]: got en/busy/ring=%b%b/%0d want 00/0", i, chime_en, busy, ring_count);
      end
    end
  endtask

  task automatic test_hold_and_wrap;
    int n_en;
    apply_reset;
    n_en = 0;
    back_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (chime_en) n_en++;
    end
    back_btn = 1'b0;
    tick;
    n_vec++;
    if (n_en !== 8 || ring_count !== 8'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_one_chime: got en_cycles=%0d ring=%0d busy=%b want 8/1/0", n_en, ring_count, busy);
    end
    for (int k = 2; k <= 256; k++) begin
      back_btn = 1'b1; tick; back_btn = 1'b0;
      repeat (12) tick;
      if (k == 255) begin
        n_vec++;
        if (ring_count !== 8'd255 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_255: got ring=%0d busy=%b want 255/0", ring_count, busy);
        end
      end
    end
    n_vec++;
    if (ring_count !== 8'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_0: got ring=%0d busy=%b want 0/0", ring_count, busy);
    end
  endtask

  initial begin
    test_reset;
    test_front;
    test_back;
    test_simultaneous;
    test_replay;
    test_reset_mid;
    test_hold_and_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
